// File: rtl/vliw_wb_arbiter_pkg.sv
// Shared definitions for the VLIW write-back path: bundle geometry, FSM states
// and a helper for sizing slot-index fields.
package vliw_wb_arbiter_pkg;

    localparam int unsigned NSLOT_DEF = 10;
    localparam int unsigned W_DEF     = 32;
    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned NWP_DEF   = 2;
    localparam int unsigned WCNT_W    = 16;

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } wb_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vliw_wb_arbiter_if.sv
// Bundle handshake between the execute slots (master) and the write-back arbiter (slave).
interface vliw_wb_arbiter_if #(
    parameter int unsigned NSLOT = 10,
    parameter int unsigned W     = 32,
    parameter int unsigned AW    = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [NSLOT-1:0]      in_wvalid;
    logic [NSLOT*AW-1:0]   in_rd;
    logic [NSLOT*W-1:0]    in_data;

    modport master (
        output in_valid, in_wvalid, in_rd, in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_wvalid, in_rd, in_data,
        output in_ready
    );
endinterface

// File: rtl/vliw_wb_arbiter_picker.sv
// Combinational slot picker: selects up to NWP pending slots in ascending order,
// skipping any slot whose rd matches a lower pending slot.
module wb_slot_picker #(
    parameter int unsigned NSLOT = 10,
    parameter int unsigned AW    = 5,
    parameter int unsigned NWP   = 2,
    parameter int unsigned SW    = 4
) (
    input  logic [NSLOT-1:0]    mask,
    input  logic [NSLOT*AW-1:0] rd,
    output logic [NWP*SW-1:0]   port_slot,
    output logic [NWP-1:0]      port_valid,
    output logic [NSLOT-1:0]    issued,
    output logic                last_group
);
    int unsigned cnt;
    logic        conflict;

    always_comb begin
        port_slot  = '0;
        port_valid = '0;
        issued     = '0;
        cnt        = 0;
        conflict   = 1'b0;
        for (int unsigned s = 0; s < NSLOT; s++) begin
            // A lower pending slot to the same rd blocks this one, selected or not.
            conflict = 1'b0;
            for (int unsigned t = 0; t < s; t++) begin
                if (mask[t] && (rd[t*AW +: AW] == rd[s*AW +: AW])) begin
                    conflict = 1'b1;
                end
            end
            if (mask[s] && !conflict && (cnt < NWP)) begin
                issued[s]                 = 1'b1;
                port_valid[cnt]           = 1'b1;
                port_slot[cnt*SW +: SW]   = SW'(s);
                cnt                       = cnt + 1;
            end
        end
        last_group = (mask != '0) && (issued == mask);
    end
endmodule

// File: rtl/vliw_wb_arbiter.sv
// Write-back arbiter: latches one retiring bundle and drains its slot results onto
// NWP register-file write ports in program order, never writing one rd twice per cycle.
module vliw_wb_arbiter
    import vliw_wb_arbiter_pkg::*;
#(
    parameter int unsigned NSLOT   = NSLOT_DEF,
    parameter int unsigned W       = W_DEF,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned NWP     = NWP_DEF,
    parameter bit          DROP_R0 = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vliw_wb_arbiter_if.slave      bif,
    input  logic                  rf_stall,
    output logic [NWP-1:0]        wr_en,
    output logic [NWP*AW-1:0]     wr_addr,
    output logic [NWP*W-1:0]      wr_data,
    output logic                  busy,
    output logic                  bundle_done,
    output logic [WCNT_W-1:0]     wr_count
);
    localparam int unsigned SW = idx_w(NSLOT);

    wb_state_e             state_q, state_d;
    logic [NSLOT-1:0]      mask_q, mask_d, new_mask;
    logic [NSLOT*AW-1:0]   rd_q;
    logic [NSLOT*W-1:0]    data_q;
    logic                  done_q;

    logic [NWP*SW-1:0]     port_slot;
    logic [NWP-1:0]        port_valid;
    logic [NSLOT-1:0]      issued;
    logic                  last_group;

    logic                  drain, go, last_issue, accept;
    logic [SW-1:0]         sel;
    logic [WCNT_W-1:0]     issue_cnt;

    wb_slot_picker #(
        .NSLOT (NSLOT),
        .AW    (AW),
        .NWP   (NWP),
        .SW    (SW)
    ) u_picker (
        .mask       (mask_q),
        .rd         (rd_q),
        .port_slot  (port_slot),
        .port_valid (port_valid),
        .issued     (issued),
        .last_group (last_group)
    );

    always_comb begin
        drain        = (state_q == ST_DRAIN);
        go           = drain && !rf_stall;
        last_issue   = go && last_group;
        bif.in_ready = (state_q == ST_IDLE) || last_issue;
        accept       = bif.in_valid && bif.in_ready;
        for (int unsigned s = 0; s < NSLOT; s++) begin
            new_mask[s] = bif.in_wvalid[s] &&
                          !(DROP_R0 && (bif.in_rd[s*AW +: AW] == '0));
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        if (go) begin
            mask_d = mask_q & ~issued;
        end
        if (last_issue) begin
            state_d = ST_IDLE;
        end
        // Acceptance only happens in IDLE or on the last group, when mask is already empty.
        if (accept) begin
            mask_d  = new_mask;
            state_d = (new_mask != '0) ? ST_DRAIN : ST_IDLE;
        end
    end

    always_comb begin
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        issue_cnt = '0;
        sel       = '0;
        for (int unsigned p = 0; p < NWP; p++) begin
            sel                 = port_slot[p*SW +: SW];
            wr_en[p]            = go && port_valid[p];
            wr_addr[p*AW +: AW] = port_valid[p] ? rd_q[sel*AW +: AW] : '0;
            wr_data[p*W +: W]   = port_valid[p] ? data_q[sel*W +: W] : '0;
            issue_cnt           = issue_cnt + WCNT_W'(wr_en[p]);
        end
        busy        = drain;
        bundle_done = done_q || last_issue;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            rd_q     <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            wr_count <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            done_q   <= accept && (new_mask == '0);
            wr_count <= wr_count + issue_cnt;
            if (accept) begin
                rd_q   <= bif.in_rd;
                data_q <= bif.in_data;
            end
        end
    end
endmodule

// File: tb/tb_vliw_wb_arbiter.sv
// Scoreboard bench for vliw_wb_arbiter: directed bundles push expected writes,
// a negedge monitor pops and compares every issued write.
module tb_vliw_wb_arbiter;
    import vliw_wb_arbiter_pkg::*;

    localparam int unsigned NSLOT = 10;
    localparam int unsigned W     = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NWP   = 2;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b0;
    logic                 rf_stall = 1'b0;
    logic [NWP-1:0]       wr_en;
    logic [NWP*AW-1:0]    wr_addr;
    logic [NWP*W-1:0]     wr_data;
    logic                 busy;
    logic                 bundle_done;
    logic [15:0]          wr_count;

    vliw_wb_arbiter_if #(.NSLOT(NSLOT), .W(W), .AW(AW)) bif ();

    vliw_wb_arbiter #(
        .NSLOT   (NSLOT),
        .W       (W),
        .AW      (AW),
        .NWP     (NWP),
        .DROP_R0 (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bif         (bif),
        .rf_stall    (rf_stall),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .bundle_done (bundle_done),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned     port;
        logic [AW-1:0]   addr;
        logic [W-1:0]    data;
    } wexp_t;

    wexp_t       exp_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          done_seen = 0;
    int          done_exp  = 0;
    bit          mon_en    = 1'b0;
    logic [15:0] exp_cnt   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic expw(input int unsigned p, input logic [AW-1:0] a, input logic [W-1:0] d);
        wexp_t e;
        e.port = p;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic clr();
        bif.in_wvalid = '0;
        bif.in_rd     = '0;
        bif.in_data   = '0;
    endtask

    task automatic slot(input int unsigned s, input logic [AW-1:0] rd, input logic [W-1:0] d);
        bif.in_wvalid[s]        = 1'b1;
        bif.in_rd[s*AW +: AW]   = rd;
        bif.in_data[s*W +: W]   = d;
    endtask

    // Holds in_valid until accepted; returns 1ns after the accepting edge.
    task automatic offer(output int waits);
        waits = 0;
        bif.in_valid = 1'b1;
        do begin
            @(negedge clk);
            waits++;
        end while (bif.in_ready !== 1'b1 && waits < 50);
        if (bif.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low expected=in_ready_high");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_chk(input string tag, input logic [1:0] we, input logic done,
                           input logic rdy, input logic bsy);
        @(negedge clk);
        check($sformatf("%s_wr_en", tag), 32'(wr_en), 32'(we));
        check($sformatf("%s_done", tag), 32'(bundle_done), 32'(done));
        check($sformatf("%s_in_ready", tag), 32'(bif.in_ready), 32'(rdy));
        check($sformatf("%s_busy", tag), 32'(busy), 32'(bsy));
    endtask

    always @(negedge clk) begin
        wexp_t e;
        if (mon_en) begin
            for (int p = 0; p < NWP; p++) begin
                if (wr_en[p] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual=port%0d r%0d=0x%0h expected=no_write",
                                 p, wr_addr[p*AW +: AW], wr_data[p*W +: W]);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_port", 32'(p), 32'(e.port));
                        check("wr_addr", 32'(wr_addr[p*AW +: AW]), 32'(e.addr));
                        check("wr_data", wr_data[p*W +: W], e.data);
                    end
                end
            end
            if (bundle_done === 1'b1) done_seen++;
        end
    end

    initial begin
        int waits;
        int unsigned remaining;
        int unsigned nfull;
        int unsigned rem;
        logic [W-1:0] d;

        bif.in_valid = 1'b0;
        clr();

        // Power-on reset
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("por_wr_en", 32'(wr_en), 32'h0);
        check("por_busy", 32'(busy), 32'h0);
        check("por_in_ready", 32'(bif.in_ready), 32'h1);
        check("por_done", 32'(bundle_done), 32'h0);
        check("por_wr_count", 32'(wr_count), 32'h0);

        // 1. Reset held two cycles mid-drain
        @(posedge clk); #1;
        clr();
        for (int unsigned s = 0; s < NSLOT; s++) slot(s, 5'(s + 1), 32'h1000 + s);
        expw(0, 5'd1, 32'h1000);
        expw(1, 5'd2, 32'h1001);
        offer(waits);
        bif.in_valid = 1'b0;
        clr();
        rst_n = 1'b0;
        cyc_chk("t1_c1", 2'b11, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_rst_wr_en", 32'(wr_en), 32'h0);
        check("t1_rst_busy", 32'(busy), 32'h0);
        check("t1_rst_in_ready", 32'(bif.in_ready), 32'h1);
        check("t1_rst_wr_count", 32'(wr_count), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_no_stale", 32'(wr_en), 32'h0);
        end

        // 2. Basic drain: slots 0,3,7 -> r8,r2,r3
        @(posedge clk); #1;
        clr();
        slot(0, 5'd8, 32'hAAAA_0000);
        slot(3, 5'd2, 32'hBBBB_1111);
        slot(7, 5'd3, 32'hCCCC_2222);
        expw(0, 5'd8, 32'hAAAA_0000);
        expw(1, 5'd2, 32'hBBBB_1111);
        expw(0, 5'd3, 32'hCCCC_2222);
        done_exp++;
        exp_cnt = exp_cnt + 16'd3;
        offer(waits);
        bif.in_valid = 1'b0;
        clr();
        cyc_chk("t2_c1", 2'b11, 1'b0, 1'b0, 1'b1);
        cyc_chk("t2_c2", 2'b01, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("t2_wr_count", 32'(wr_count), 32'(exp_cnt));
        check("t2_idle", 32'(busy), 32'h0);

        // 3. Same-rd ordering: slots 1,2 -> r5, slot 4 -> r6
        @(posedge clk); #1;
        clr();
        slot(1, 5'd5, 32'h0000_00A1);
        slot(2, 5'd5, 32'h0000_00B2);
        slot(4, 5'd6, 32'h0000_00C3);
        expw(0, 5'd5, 32'h0000_00A1);
        expw(1, 5'd6, 32'h0000_00C3);
        expw(0, 5'd5, 32'h0000_00B2);
        done_exp++;
        exp_cnt = exp_cnt + 16'd3;
        offer(waits);
        bif.in_valid = 1'b0;
        clr();
        cyc_chk("t3_c1", 2'b11, 1'b0, 1'b0, 1'b1);
        cyc_chk("t3_c2", 2'b01, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("t3_wr_count", 32'(wr_count), 32'(exp_cnt));

        // 4. r0 drop
        @(posedge clk); #1;
        clr();
        slot(0, 5'd0, 32'hDEAD_BEEF);
        done_exp++;
        offer(waits);
        bif.in_valid = 1'b0;
        clr();
        cyc_chk("t4_c1", 2'b00, 1'b1, 1'b1, 1'b0);
        cyc_chk("t4_c2", 2'b00, 1'b0, 1'b1, 1'b0);
        check("t4_wr_count", 32'(wr_count), 32'(exp_cnt));

        // 5. Stall during T+2..T+4
        @(posedge clk); #1;
        clr();
        for (int unsigned s = 0; s < 5; s++) begin
            slot(s, 5'(11 + s), 32'h5000 + s);
            expw(s % 2, 5'(11 + s), 32'h5000 + s);
        end
        done_exp++;
        exp_cnt = exp_cnt + 16'd5;
        offer(waits);
        bif.in_valid = 1'b0;
        clr();
        cyc_chk("t5_c1", 2'b11, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1 rf_stall = 1'b1;
        cyc_chk("t5_c2", 2'b00, 1'b0, 1'b0, 1'b1);
        cyc_chk("t5_c3", 2'b00, 1'b0, 1'b0, 1'b1);
        cyc_chk("t5_c4", 2'b00, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1 rf_stall = 1'b0;
        cyc_chk("t5_c5", 2'b11, 1'b0, 1'b0, 1'b1);
        cyc_chk("t5_c6", 2'b01, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("t5_wr_count", 32'(wr_count), 32'(exp_cnt));

        // Preload wr_count to 0xFFFF with back-to-back 10-write bundles
        remaining = 32'h0000_FFFF - 32'(exp_cnt);
        nfull = remaining / NSLOT;
        rem   = remaining % NSLOT;
        @(posedge clk); #1;
        for (int unsigned b = 0; b < nfull; b++) begin
            clr();
            for (int unsigned s = 0; s < NSLOT; s++) begin
                d = {16'(b), 16'(s)};
                slot(s, 5'(s + 1), d);
                expw(s % 2, 5'(s + 1), d);
            end
            done_exp++;
            offer(waits);
        end
        if (rem != 0) begin
            clr();
            for (int unsigned s = 0; s < rem; s++) begin
                d = {16'hFFFF, 16'(s)};
                slot(s, 5'(s + 1), d);
                expw(s % 2, 5'(s + 1), d);
            end
            done_exp++;
            offer(waits);
        end
        bif.in_valid = 1'b0;
        clr();
        repeat (6) @(negedge clk);
        check("pre_wr_count", 32'(wr_count), 32'h0000_FFFF);
        check("pre_idle", 32'(busy), 32'h0);

        // 6. Back-to-back 2-write bundles across the wrap
        @(posedge clk); #1;
        clr();
        slot(0, 5'd20, 32'hE000_0000);
        slot(1, 5'd21, 32'hE000_0001);
        expw(0, 5'd20, 32'hE000_0000);
        expw(1, 5'd21, 32'hE000_0001);
        done_exp++;
        offer(waits);
        check("t6_first_accept_waits", 32'(waits), 32'h1);
        clr();
        slot(2, 5'd22, 32'hF000_0002);
        slot(5, 5'd23, 32'hF000_0005);
        expw(0, 5'd22, 32'hF000_0002);
        expw(1, 5'd23, 32'hF000_0005);
        done_exp++;
        offer(waits);
        check("t6_no_bubble_waits", 32'(waits), 32'h1);
        bif.in_valid = 1'b0;
        clr();
        cyc_chk("t6_c2", 2'b11, 1'b1, 1'b1, 1'b1);
        check("t6_wrap_count", 32'(wr_count), 32'h0000_0001);
        cyc_chk("t6_c3", 2'b00, 1'b0, 1'b1, 1'b0);
        check("t6_final_count", 32'(wr_count), 32'h0000_0003);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'h0);
        check("done_pulses", 32'(done_seen), 32'(done_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
